// File: rtl/free_list_mp.sv
// Multi-ported circular free list of physical registers with head-pointer
// checkpoints for mispredict recovery.
module free_list_mp #(
  parameter int NUM_PR   = 64,
  parameter int NUM_ARCH = 32,
  parameter int DEQ_N    = 2,
  parameter int ENQ_N    = 2,
  parameter int NUM_CKPT = 4,
  localparam int PR_W    = $clog2(NUM_PR),
  localparam int PTR_W   = PR_W + 1,
  localparam int CK_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DEQ_N-1:0]             deq_req,
  output logic [DEQ_N-1:0][PR_W-1:0]   deq_pr,
  output logic                         deq_ok,
  input  logic [ENQ_N-1:0]             enq_valid,
  input  logic [ENQ_N-1:0][PR_W-1:0]   enq_pr,
  input  logic                         ckpt_save,
  input  logic [CK_W-1:0]              ckpt_save_id,
  input  logic                         ckpt_restore,
  input  logic [CK_W-1:0]              ckpt_restore_id,
  output logic [PTR_W-1:0]             free_count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow_err
);

  logic [PR_W-1:0]  list [NUM_PR];
  logic [PTR_W-1:0] ckpt [NUM_CKPT];
  logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
  logic [PTR_W-1:0] deq_k, enq_k, grant;
  logic [PR_W-1:0]  widx [ENQ_N];
  logic [PTR_W:0]   ovf_sum;

  // Read ports see only registered list contents: no enqueue bypass.
  for (genvar i = 0; i < DEQ_N; i++) begin : g_rd
    assign deq_pr[i] = list[PR_W'(head + PTR_W'(i))];
  end

  always_comb begin
    deq_k = '0;
    for (int i = 0; i < DEQ_N; i++) deq_k = deq_k + PTR_W'(deq_req[i]);
    // Valid enqueue ports are packed in port order starting at tail.
    enq_k = '0;
    for (int i = 0; i < ENQ_N; i++) begin
      widx[i] = PR_W'(tail + enq_k);
      enq_k   = enq_k + PTR_W'(enq_valid[i]);
    end
  end

  assign deq_ok   = (deq_k <= free_count) && !ckpt_restore;
  assign grant    = deq_ok ? deq_k : '0;
  assign head_nxt = ckpt_restore ? ckpt[ckpt_restore_id] : head + grant;
  assign tail_nxt = tail + enq_k;
  assign ovf_sum  = (PTR_W+1)'(free_count) + (PTR_W+1)'(enq_k) - (PTR_W+1)'(grant);

  assign empty = (free_count == '0);
  assign full  = (free_count == PTR_W'(NUM_PR));

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= PTR_W'(NUM_PR - NUM_ARCH);
      free_count   <= PTR_W'(NUM_PR - NUM_ARCH);
      overflow_err <= 1'b0;
      for (int i = 0; i < NUM_CKPT; i++) ckpt[i] <= '0;
      for (int i = 0; i < NUM_PR; i++)
        list[i] <= (i < NUM_PR - NUM_ARCH) ? PR_W'(NUM_ARCH + i) : '0;
    end else begin
      head       <= head_nxt;
      tail       <= tail_nxt;
      free_count <= tail_nxt - head_nxt;
      // A save alongside a restore captures the restored head.
      if (ckpt_save) ckpt[ckpt_save_id] <= head_nxt;
      if (ovf_sum > (PTR_W+1)'(NUM_PR)) overflow_err <= 1'b1;
      for (int i = 0; i < ENQ_N; i++)
        if (enq_valid[i]) list[widx[i]] <= enq_pr[i];
    end
  end

endmodule

// File: tb/tb_free_list_mp.sv
// Randomized and directed checks of free_list_mp against an unbounded-counter
// queue model of the free list.
module tb_free_list_mp;
  localparam int NUM_PR = 64, NUM_ARCH = 32, DEQ_N = 2, ENQ_N = 2, NUM_CKPT = 4;
  localparam int PR_W = 6, PTR_W = 7, CK_W = 2;

  logic clk = 1'b0;
  logic reset;
  logic [DEQ_N-1:0]           deq_req;
  logic [DEQ_N-1:0][PR_W-1:0] deq_pr;
  logic                       deq_ok;
  logic [ENQ_N-1:0]           enq_valid;
  logic [ENQ_N-1:0][PR_W-1:0] enq_pr;
  logic                       ckpt_save, ckpt_restore;
  logic [CK_W-1:0]            ckpt_save_id, ckpt_restore_id;
  logic [PTR_W-1:0]           free_count;
  logic                       empty, full, overflow_err;

  always #5 clk = ~clk;

  free_list_mp dut (
    .clk(clk), .reset(reset), .deq_req(deq_req), .deq_pr(deq_pr), .deq_ok(deq_ok),
    .enq_valid(enq_valid), .enq_pr(enq_pr), .ckpt_save(ckpt_save),
    .ckpt_save_id(ckpt_save_id), .ckpt_restore(ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id), .free_count(free_count), .empty(empty),
    .full(full), .overflow_err(overflow_err));

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: head/tail are plain ever-growing counts of PRs handed out / returned.
  int mh, mt;
  int mem [NUM_PR];
  int mck [NUM_CKPT];
  bit mov;

  function automatic int mfc();
    return (mt - mh) % (2 * NUM_PR);
  endfunction

  function automatic int pop2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  function automatic bit m_ok();
    return (pop2(deq_req) <= mfc()) && !ckpt_restore;
  endfunction

  task automatic model_reset();
    mh = 0; mt = NUM_PR - NUM_ARCH; mov = 0;
    for (int i = 0; i < NUM_PR; i++) mem[i] = (i < NUM_PR - NUM_ARCH) ? NUM_ARCH + i : 0;
    for (int i = 0; i < NUM_CKPT; i++) mck[i] = 0;
  endtask

  task automatic idle();
    deq_req = '0; enq_valid = '0; enq_pr = '0;
    ckpt_save = 0; ckpt_restore = 0; ckpt_save_id = '0; ckpt_restore_id = '0;
  endtask

  // Called just after a posedge with inputs set; checks, then advances one clock.
  task automatic step();
    int g, e, nh, fc;
    @(negedge clk);
    chk("deq_ok", deq_ok, m_ok());
    for (int i = 0; i < DEQ_N; i++) chk($sformatf("deq_pr%0d", i), deq_pr[i], mem[(mh + i) % NUM_PR]);
    chk("free_count", free_count, mfc());
    chk("empty", empty, mfc() == 0);
    chk("full", full, mfc() == NUM_PR);
    chk("overflow_err", overflow_err, mov);
    @(posedge clk);
    fc = mfc();
    g  = m_ok() ? pop2(deq_req) : 0;
    e  = 0;
    for (int i = 0; i < ENQ_N; i++)
      if (enq_valid[i]) begin mem[(mt + e) % NUM_PR] = enq_pr[i]; e++; end
    if (fc + e - g > NUM_PR) mov = 1;
    nh = ckpt_restore ? mck[ckpt_restore_id] : mh + g;
    if (ckpt_save) mck[ckpt_save_id] = nh;
    mt += e; mh = nh;
    #1;
  endtask

  task automatic do_reset();
    // Reset must win over a concurrent restore and traffic.
    reset = 1; ckpt_restore = 1; ckpt_restore_id = 2'd3; deq_req = 2'b11; enq_valid = 2'b11;
    @(posedge clk); @(posedge clk); #1;
    reset = 0; idle(); model_reset();
  endtask

  initial begin
    int r, v, rid, pr4;
    idle(); reset = 1;
    do_reset();
    #3;
    chk("rst_free_count", free_count, 32);
    chk("rst_deq_pr0", deq_pr[0], 32);
    chk("rst_deq_pr1", deq_pr[1], 33);
    chk("rst_empty", empty, 0);
    chk("rst_full", full, 0);
    step();

    deq_req = 2'b11; step(); idle();
    #3; chk("two_alloc_pr0", deq_pr[0], 34); chk("two_alloc_pr1", deq_pr[1], 35);
    chk("two_alloc_fc", free_count, 30);
    deq_req = 2'b01; step();
    deq_req = 2'b11;
    while (mfc() > 1) step();
    #3; chk("short_deq_ok", deq_ok, 0);
    step();
    chk("short_fc_held", free_count, 1);
    deq_req = 2'b01; step(); idle();
    #3; chk("drained_empty", empty, 1);

    enq_valid = 2'b10; enq_pr[0] = 6'd9; enq_pr[1] = 6'd5; step(); idle();
    #3; chk("enq_visible_next", deq_pr[0], 5);
    step();

    // Checkpoint at head 4, consume 6 more, then roll back.
    do_reset();
    deq_req = 2'b11; step(); step(); idle();
    pr4 = mem[4];
    ckpt_save = 1; ckpt_save_id = 2'd1; step(); idle();
    deq_req = 2'b11; step(); step(); step();
    ckpt_restore = 1; ckpt_restore_id = 2'd1;
    #3; chk("restore_blocks_deq", deq_ok, 0);
    step(); idle();
    #3; chk("restore_head_pr", deq_pr[0], pr4);
    chk("restore_fc", free_count, 28);
    step();

    // Random traffic kept within capacity.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 2);
      deq_req = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      v = $urandom_range(0, 3);
      if (pop2(2'(v)) > NUM_PR - mfc()) v = 0;
      enq_valid = 2'(v);
      enq_pr[0] = 6'($urandom); enq_pr[1] = 6'($urandom);
      ckpt_save = ($urandom_range(0, 7) == 0); ckpt_save_id = 2'($urandom);
      rid = $urandom_range(0, NUM_CKPT - 1);
      ckpt_restore_id = 2'(rid);
      ckpt_restore = ($urandom_range(0, 9) == 0) && (mt + pop2(2'(v)) - mck[rid] <= NUM_PR);
      step();
    end
    idle();

    // Tail crossing 63 -> 0 with a two-port write, then read across it.
    do_reset();
    deq_req = 2'b11; while (mfc() > 0) step();
    idle(); enq_valid = 2'b11;
    while (mt % NUM_PR != 63) begin
      if (mt % NUM_PR == 62) enq_valid = 2'b01;
      enq_pr[0] = 6'($urandom); enq_pr[1] = 6'($urandom);
      step();
    end
    enq_valid = 2'b11; enq_pr[0] = 6'd17; enq_pr[1] = 6'd23; step(); idle();
    deq_req = 2'b11; while (mh % NUM_PR != 62) step();
    deq_req = 2'b01; step(); idle();
    #3; chk("wrap_rd63", deq_pr[0], 17); chk("wrap_rd0", deq_pr[1], 23);
    step();

    // Fill to full, then push one extra.
    while (mfc() < NUM_PR) begin
      enq_valid = (mfc() == NUM_PR - 1) ? 2'b01 : 2'b11;
      enq_pr[0] = 6'($urandom); enq_pr[1] = 6'($urandom);
      step();
    end
    idle();
    #3; chk("full_flag", full, 1); chk("no_ovf_yet", overflow_err, 0);
    enq_valid = 2'b01; enq_pr[0] = 6'd1; step(); idle();
    #3; chk("ovf_set", overflow_err, 1);
    deq_req = 2'b11; step(); step(); idle(); step();
    chk("ovf_sticky", overflow_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule

// File: doc/free_list_mp.md
FREE_LIST_MP -- requirements
Module: free_list_mp

Interface
REQ-001 The block SHALL take parameter NUM_PR, default 64, as the number of physical registers and list depth; it SHALL be a power of two.
REQ-002 The block SHALL take parameter NUM_ARCH, default 32, as the number of architectural registers; it SHALL be less than NUM_PR.
REQ-003 The block SHALL take parameter DEQ_N, default 2, as the number of dequeue (allocate) ports.
REQ-004 The block SHALL take parameter ENQ_N, default 2, as the number of enqueue (free) ports.
REQ-005 The block SHALL take parameter NUM_CKPT, default 4, as the number of head-pointer checkpoints.
REQ-006 Derived widths SHALL be: PR_W = clog2(NUM_PR); PTR_W = PR_W+1, where the MSB is the wrap bit.
REQ-007 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- deq_req  in  DEQ_N  per-port allocate request; set bits are contiguous from bit 0
- deq_pr  out  DEQ_N x PR_W  PR offered on each port, combinational
- deq_ok  out  1  all requested ports are granted this cycle, combinational
- enq_valid  in  ENQ_N  per-port free request
- enq_pr  in  ENQ_N x PR_W  PR to free on each port
- ckpt_save  in  1  save checkpoint
- ckpt_save_id  in  clog2(NUM_CKPT)  checkpoint slot to save
- ckpt_restore  in  1  restore checkpoint (mispredict)
- ckpt_restore_id  in  clog2(NUM_CKPT)  checkpoint slot to restore
- free_count  out  PTR_W  number of free PRs, registered
- empty  out  1  free_count == 0
- full  out  1  free_count == NUM_PR
- overflow_err  out  1  sticky error flag

Function
REQ-008 Storage SHALL be NUM_PR entries of PR_W bits addressed by the low PR_W bits of head and tail; no slot is sacrificed, and full/empty SHALL derive from free_count = tail - head (mod 2^PTR_W).
REQ-009 deq_pr[i] SHALL equal list[(head+i) mod NUM_PR] for every i, regardless of deq_req.
REQ-010 Let k = popcount(deq_req); deq_ok SHALL be 1 iff k <= free_count and ckpt_restore = 0.
REQ-011 Grant SHALL be all-or-nothing: if deq_ok, head advances by k at the next edge; otherwise head is unchanged and no PR is consumed.
REQ-012 Enqueues SHALL always be accepted: valid ports are packed in port order and written starting at tail, and tail advances by popcount(enq_valid).
REQ-013 There SHALL be no same-cycle bypass: an enqueued PR is first visible on deq_pr the cycle after the write.
REQ-014 If free_count + popcount(enq_valid) - (granted k) > NUM_PR, overflow_err SHALL set and stay set until reset; the writes still occur.
REQ-015 ckpt_save SHALL store the next-cycle head (after this cycle's granted dequeues) into slot ckpt_save_id.
REQ-016 ckpt_restore SHALL load head from slot ckpt_restore_id at the next edge; dequeues are blocked that cycle.
REQ-017 Enqueues in a restore cycle SHALL still apply.
REQ-018 If save and restore occur in the same cycle, restore SHALL take effect, and the saved value SHALL be the restored head.
REQ-019 free_count SHALL be recomputed from the new head/tail every cycle, including after a restore.
REQ-020 Pointer arithmetic SHALL be modulo 2^PTR_W; wrap-around across index NUM_PR-1 -> 0 SHALL be seamless for multi-port reads and writes.

Reset
REQ-021 On reset: head = 0, tail = NUM_PR-NUM_ARCH, list[i] = NUM_ARCH+i for i < NUM_PR-NUM_ARCH, all checkpoints = 0, overflow_err = 0.
REQ-022 One cycle after reset with defaults: free_count = 32, empty = 0, full = 0, deq_pr[0] = 32, deq_pr[1] = 33.
REQ-023 Reset SHALL override every concurrent request, including an in-flight restore.

Verification
REQ-024 Reset, then deq_req = 2'b11 for 1 cycle -> deq_ok = 1; next cycle deq_pr = {34,35}, free_count = 30.
REQ-025 Drain to free_count = 1, deq_req = 2'b11 -> deq_ok = 0, head and free_count unchanged; deq_req = 2'b01 -> granted, empty = 1 next cycle.
REQ-026 From empty, enq_valid = 2'b10 with enq_pr[1] = 5 -> deq_pr[0] = 5 the next cycle, not the same cycle.
REQ-027 ckpt_save id 1 at head = 4, dequeue 6 PRs, ckpt_restore id 1 with deq_req = 2'b11 -> deq_ok = 0; next cycle head = 4, deq_pr[0] = the same PR originally at head 4.
REQ-028 Cycle tail past index 63 with 2 enqueues per cycle, at 63 and 0 -> correct split write and read; from full, one extra enqueue -> overflow_err = 1 and it stays 1.
